fifo_1_ctrl: RTL
================

# fifo_1_ctrl

Access controller for the `fifo_1` byte FIFO. It arbitrates `NREQ` write requesters round-robin onto the single FIFO write port and serves one read consumer. It tracks occupancy so it can provide full/empty/count, which `fifo_1` does not. It sits between the producer/consumer logic and `fifo_1` and is the only driver of `fifo_1`'s `data_in`, `enable_wrt` and `enable_rd`.

## Interface
- `NREQ`, 2: number of write requesters (2..8).
- `DEPTH`, 8: entry count of the attached `fifo_1`.
- `CW`, `$clog2(DEPTH+1)`: count width (derived, not overridden).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `wr_req`  in  NREQ  per-requester write request (level).
- `wr_data`  in  8*NREQ  requester i data in bits [8i+7:8i].
- `wr_gnt`  out  NREQ  one-hot, one-cycle grant; data taken.
- `rd_req`  in  1  consumer read request (level).
- `rd_data`  out  8  read byte.
- `rd_valid`  out  1  one-cycle strobe qualifying `rd_data`.
- `fifo_din`  out  8  to `fifo_1.data_in`.
- `fifo_wen`  out  1  to `fifo_1.enable_wrt`.
- `fifo_ren`  out  1  to `fifo_1.enable_rd`.
- `fifo_dout`  in  8  from `fifo_1.data_out`.
- `count`  out  CW  occupancy 0..DEPTH.
- `full` / `empty`  out  1  `count==DEPTH` / `count==0`.

## Operation
- FSM states: IDLE, ISSUE, GAP.
  - IDLE: at each edge, evaluate eligibility.
    - Read is eligible when `rd_req & !empty`.
    - Write is eligible when `|wr_req & !full`.
    - If either is eligible, register the operation and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: exactly one of `fifo_wen` / `fifo_ren` is high for this one cycle, then go to GAP.
  - GAP: all strobes low for one cycle, then go to IDLE.
  - At most one FIFO operation is issued per 3 cycles. The enable pulse is always followed by a low cycle.
- Write issue:
  - The winner index is registered with `wr_gnt` one-hot.
  - `fifo_din` is loaded from the winner's `wr_data`.
  - `fifo_wen` is set to 1.
  - `count` increments on the same edge.
- Read issue: `fifo_ren` is set to 1 and `count` decrements on the same edge.
- Round-robin: the pointer holds the last granted index. The search starts at pointer+1, modulo NREQ. Reset pointer = NREQ-1, so requester 0 wins first.
- Read/write fairness:
  - When both are eligible, choose the opposite of `last_op`.
  - `last_op` resets to WRITE, so a read wins the first tie.
  - When only one is eligible, it wins regardless of `last_op`.
- Requester handshake:
  - `wr_data` is held stable while `wr_req` is high.
  - The GAP and IDLE cycles give the requester time to drop or update `wr_req`. A request still high at the next IDLE evaluation is a new write.
- Read path: `rd_data <= fifo_dout` and `rd_valid <= 1` one cycle after the ISSUE(read) cycle.
- Boundaries:
  - `rd_req` while empty is ignored, with no `fifo_ren`.
  - `wr_req` while full is ignored, with no grant; the requester keeps waiting.
  - `count` never leaves 0..DEPTH.
- Reset:
  - All outputs clear: `wr_gnt=0`, `fifo_wen=0`, `fifo_ren=0`, `fifo_din=0`, `rd_data=0`, `rd_valid=0`, `count=0`, `empty=1`, `full=0`.
  - FSM goes to IDLE, pointer = NREQ-1, `last_op`=WRITE.
  - A read in flight when `rst` goes low is dropped, with no `rd_valid`.
  - `fifo_1` shares `rst`, so occupancy stays consistent.

## Timing
- Edge E: decision; ISSUE is the cycle after E.
  - Write: `wr_gnt`, `fifo_wen` and `fifo_din` are valid in ISSUE.
  - Read: `fifo_ren` is high in ISSUE, `fifo_1` reads at edge E+1, and `rd_valid` is high in the cycle after E+2.
  - `rd_req` sampled at E gives `rd_valid` 2 cycles after ISSUE starts.
- `count`, `full` and `empty` update at the decision edge E, so they are registered and glitch-free.
- Maximum throughput: one byte per 3 cycles.

## Structure
- Package `fifo_ctrl_pkg`:
  - `DATA_W=8`.
  - State enum {IDLE, ISSUE, GAP}.
  - Operation enum {OP_WRITE, OP_READ}.
- Sub-module `rr_arbiter`:
  - Parameter NREQ.
  - Ports: `req`, `ptr` in, `gnt_onehot`, `gnt_idx` out.
  - Combinational. The pointer register stays in `fifo_1_ctrl`.

## Test plan
- Reset: hold `rst`=0 for 2 edges → all outputs 0, `empty`=1, `count`=0. Release with no requests → FSM stays IDLE and no strobes.
- Single writer: `wr_req`=2'b01, `wr_data[7:0]`=8'h08 → `wr_gnt`=01 and `fifo_wen`=1 for one cycle with `fifo_din`=08, then `count`=1 and `empty`=0.
- Contention and full: NREQ=2, both requests held with data 09/0A.
  - Grants alternate 0,1,0,1, one every 3 cycles.
  - After 8 grants: `full`=1, no further `fifo_wen`, `count` stays at 8.
- Drain: write 08, 09, 0C, then hold `rd_req`.
  - `fifo_ren` pulses every 3 cycles.
  - `rd_valid` shows 08, 09, 0C, each 2 cycles after its `fifo_ren`.
  - `count` returns to 0, `empty`=1, and no further `fifo_ren`.
- Read/write tie: `count`=4, with `rd_req` and `wr_req[0]` held.
  - Operations are R, W, R, W…, with R first after reset.
  - `count` alternates 3/4.
- Reset mid-read: drive `rst`=0 in the cycle after `fifo_ren` → `rd_valid` never asserts, `count`=0, `empty`=1.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: shared types and constants for the fifo_1 access controller
package fifo_ctrl_pkg;
   localparam int DATA_W = 8;
   typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;
   typedef enum logic {OP_WRITE, OP_READ} op_t;
endpackage

// File: rtl/fifo_1_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr+1
module rr_arbiter #(
   parameter int NREQ = 2,
   localparam int IW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] gnt_onehot,
   output logic [IW-1:0]   gnt_idx
);
   int c;
   always_comb begin
      gnt_idx = '0;
      c = 0;
      // walk from farthest to nearest so the nearest requester after ptr wins
      for (int k = NREQ; k >= 1; k--) begin
         c = (int'(ptr) + k) % NREQ;
         if (req[c]) gnt_idx = IW'(c);
      end
      gnt_onehot = |req ? NREQ'(1) << gnt_idx : '0;
   end
endmodule

// File: rtl/fifo_1_ctrl.sv
// fifo_1_ctrl: round-robin write arbitration, read service and occupancy tracking for fifo_1
module fifo_1_ctrl
   import fifo_ctrl_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int DEPTH = 8,
   localparam int CW = $clog2(DEPTH + 1),
   localparam int IW = $clog2(NREQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        wr_req,
   input  logic [DATA_W*NREQ-1:0] wr_data,
   output logic [NREQ-1:0]        wr_gnt,
   input  logic                   rd_req,
   output logic [DATA_W-1:0]      rd_data,
   output logic                   rd_valid,
   output logic [DATA_W-1:0]      fifo_din,
   output logic                   fifo_wen,
   output logic                   fifo_ren,
   input  logic [DATA_W-1:0]      fifo_dout,
   output logic [CW-1:0]          count,
   output logic                   full,
   output logic                   empty
);
   state_t state;
   op_t last_op;
   logic [IW-1:0] ptr, gnt_idx;
   logic [NREQ-1:0] gnt_onehot;
   logic ren_d, rd_ok, wr_ok, do_rd, do_wr;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req(wr_req),
      .ptr(ptr),
      .gnt_onehot(gnt_onehot),
      .gnt_idx(gnt_idx)
   );

   assign full = count == CW'(DEPTH);
   assign empty = count == '0;
   assign rd_ok = rd_req & ~empty;
   assign wr_ok = |wr_req & ~full;
   // on a tie the side that did not go last wins
   assign do_rd = state == IDLE && rd_ok && (!wr_ok || last_op == OP_WRITE);
   assign do_wr = state == IDLE && wr_ok && !do_rd;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         last_op <= OP_WRITE;
         ptr <= IW'(NREQ - 1);
         wr_gnt <= '0;
         fifo_wen <= 1'b0;
         fifo_ren <= 1'b0;
         fifo_din <= '0;
         rd_data <= '0;
         rd_valid <= 1'b0;
         ren_d <= 1'b0;
         count <= '0;
      end else begin
         state <= state == IDLE ? (do_rd || do_wr ? ISSUE : IDLE) : state == ISSUE ? GAP : IDLE;
         wr_gnt <= do_wr ? gnt_onehot : '0;
         fifo_wen <= do_wr;
         fifo_ren <= do_rd;
         ren_d <= fifo_ren;
         rd_valid <= ren_d;
         if (ren_d) rd_data <= fifo_dout;
         if (do_wr) begin
            fifo_din <= wr_data[{gnt_idx, 3'b000} +: DATA_W];
            ptr <= gnt_idx;
            last_op <= OP_WRITE;
            count <= count + CW'(1);
         end
         if (do_rd) begin
            last_op <= OP_READ;
            count <= count - CW'(1);
         end
      end
   end
endmodule
